// File: rtl/vdma_arb_pkg.sv
// Shared types for the VDMA burst arbiters: FSM state encoding and a
// width helper usable in parameter defaults.
package vdma_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } arb_st_e;

  // ceil(log2(n)) clamped to at least 1 so a grant index always has a bit
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/axi_wr_burst_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after last+1,
// wrapping modulo NUM.
module rr_pick
  import vdma_arb_pkg::*;
#(
  parameter int NUM = 2,
  parameter int IDW = clog2(NUM)
) (
  input  logic [NUM-1:0] req,
  input  logic [IDW-1:0] last,
  output logic           vld,
  output logic [IDW-1:0] win
);

  int idx;

  always_comb begin
    vld = 1'b0;
    win = '0;
    idx = 0;
    for (int k = 1; k <= NUM; k++) begin
      idx = (int'(last) + k) % NUM;
      if (!vld && req[idx]) begin
        vld = 1'b1;
        win = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/axi_wr_burst_arb.sv
// Shares one AXI write engine between NUM stream channels; the grant is held
// for the whole burst so AW order and W data order always match.
module axi_wr_burst_arb
  import vdma_arb_pkg::*;
#(
  parameter int NUM       = 2,
  parameter int ASIZE     = 29,
  parameter int LSIZE     = 9,
  parameter int AXI_DSIZE = 256,
  parameter int IDW       = clog2(NUM)
) (
  input  logic                     axi_aclk,
  input  logic                     axi_rst,
  input  logic [NUM-1:0]           s_req,
  input  logic [NUM*LSIZE-1:0]     s_len,
  input  logic [NUM*ASIZE-1:0]     s_addr,
  input  logic [NUM*AXI_DSIZE-1:0] s_wdata,
  input  logic [NUM-1:0]           s_wvalid,
  output logic [NUM-1:0]           s_resp,
  output logic [NUM-1:0]           s_done,
  output logic [NUM-1:0]           s_pull,
  output logic                     m_req,
  output logic [LSIZE-1:0]         m_len,
  output logic [ASIZE-1:0]         m_addr,
  input  logic                     m_resp,
  input  logic                     m_done,
  input  logic                     m_pull,
  output logic [AXI_DSIZE-1:0]     m_wdata,
  output logic                     m_wvalid,
  output logic [IDW-1:0]           grant_id,
  output logic                     busy
);

  logic [NUM-1:0][LSIZE-1:0]     len_a;
  logic [NUM-1:0][ASIZE-1:0]     addr_a;
  logic [NUM-1:0][AXI_DSIZE-1:0] wdata_a;

  assign len_a   = s_len;
  assign addr_a  = s_addr;
  assign wdata_a = s_wdata;

  arb_st_e          state_q, state_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [IDW-1:0]   gid_q, gid_d;
  logic [LSIZE-1:0] len_q, len_d;
  logic [ASIZE-1:0] addr_q, addr_d;
  logic [NUM-1:0]   resp_q, resp_d;
  logic [NUM-1:0]   done_q, done_d;

  logic             pick_vld;
  logic [IDW-1:0]   pick_win;
  logic [NUM-1:0]   gnt_oh;

  rr_pick #(.NUM(NUM), .IDW(IDW)) u_pick (
    .req  (s_req),
    .last (last_q),
    .vld  (pick_vld),
    .win  (pick_win)
  );

  assign gnt_oh = NUM'(1) << gid_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gid_d   = gid_q;
    len_d   = len_q;
    addr_d  = addr_q;
    resp_d  = '0;
    done_d  = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gid_d   = pick_win;
          last_d  = pick_win;
          len_d   = len_a[pick_win];
          addr_d  = addr_a[pick_win];
          state_d = REQ;
        end
      end
      REQ: begin
        // m_done without m_resp is not a valid engine handshake here
        if (m_resp) begin
          resp_d = gnt_oh;
          if (m_done) begin
            done_d  = gnt_oh;
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (m_done) begin
          done_d  = gnt_oh;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or posedge axi_rst) begin
    if (axi_rst) begin
      state_q <= IDLE;
      last_q  <= IDW'(NUM - 1);
      gid_q   <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      resp_q  <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      resp_q  <= resp_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign m_req    = (state_q == REQ);
  assign m_len    = len_q;
  assign m_addr   = addr_q;
  assign grant_id = gid_q;
  assign s_resp   = resp_q;
  assign s_done   = done_q;

  // Engine-to-FIFO paths stay combinational so a pull reaches the FIFO the same cycle
  assign s_pull   = (busy && m_pull) ? gnt_oh : '0;
  assign m_wdata  = busy ? wdata_a[gid_q] : '0;
  assign m_wvalid = busy & s_wvalid[gid_q];

endmodule

// File: tb/tb_axi_wr_burst_arb.sv
// Randomized bench for axi_wr_burst_arb against a queue-free round-robin
// reference model that tracks only the last granted channel.
module tb_axi_wr_burst_arb;

  localparam int NUM = 4;
  localparam int ASIZE = 29;
  localparam int LSIZE = 9;
  localparam int DW = 32;
  localparam int IDW = 2;

  logic clk, rst;
  logic [NUM-1:0] s_req, s_wvalid, s_resp, s_done, s_pull;
  logic [NUM-1:0][LSIZE-1:0] len_a;
  logic [NUM-1:0][ASIZE-1:0] addr_a;
  logic [NUM-1:0][DW-1:0] wd_a;
  logic m_req, m_resp, m_done, m_pull, m_wvalid, busy;
  logic [LSIZE-1:0] m_len;
  logic [ASIZE-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [IDW-1:0] grant_id;

  int n_chk = 0;
  int n_fail = 0;
  int last_m = NUM - 1;

  axi_wr_burst_arb #(.NUM(NUM), .ASIZE(ASIZE), .LSIZE(LSIZE), .AXI_DSIZE(DW), .IDW(IDW)) dut (
    .axi_aclk(clk), .axi_rst(rst),
    .s_req(s_req), .s_len(len_a), .s_addr(addr_a), .s_wdata(wd_a), .s_wvalid(s_wvalid),
    .s_resp(s_resp), .s_done(s_done), .s_pull(s_pull),
    .m_req(m_req), .m_len(m_len), .m_addr(m_addr),
    .m_resp(m_resp), .m_done(m_done), .m_pull(m_pull),
    .m_wdata(m_wdata), .m_wvalid(m_wvalid), .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_pick(input logic [NUM-1:0] r);
    for (int k = 1; k <= NUM; k++)
      if (r[(last_m + k) % NUM]) return (last_m + k) % NUM;
    return -1;
  endfunction

  function automatic logic [NUM-1:0] oh(input int g);
    logic [NUM-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  // One full burst from an IDLE negedge; returns at the negedge where s_done is visible.
  task automatic burst(input bit same, input int npull, input bit rearm, output int g);
    int n;
    logic [LSIZE-1:0] el;
    logic [ASIZE-1:0] ea;
    g = model_pick(s_req);
    if (g < 0) begin
      chk("no_requester", 0, 1);
      return;
    end
    el = len_a[g];
    ea = addr_a[g];
    last_m = g;
    n = 0;
    do begin @(negedge clk); n++; end while (!m_req && n < 10);
    chk("grant_lat", n, 1);
    chk("grant_id", grant_id, g);
    chk("m_len", m_len, el);
    chk("m_addr", m_addr, ea);
    chk("busy_req", busy, 1);
    len_a[g] = LSIZE'($urandom);
    addr_a[g] = ASIZE'($urandom);
    repeat ($urandom_range(0, 2)) begin
      m_done = 1'($urandom_range(0, 1));
      @(negedge clk);
      m_done = 1'b0;
      chk("m_req_hold", m_req, 1);
      chk("s_done_noresp", s_done, 0);
      chk("s_resp_early", s_resp, 0);
    end
    m_resp = 1'b1;
    m_done = same;
    @(negedge clk);
    m_resp = 1'b0;
    m_done = 1'b0;
    chk("s_resp", s_resp, oh(g));
    chk("m_req_off", m_req, 0);
    s_req[g] = 1'b0;
    if (same) begin
      chk("s_done_same", s_done, oh(g));
      chk("busy_same", busy, 0);
    end else begin
      chk("s_done_early", s_done, 0);
      for (int i = 0; i < npull; i++) begin
        m_pull = 1'($urandom_range(0, 1));
        s_wvalid = NUM'($urandom);
        for (int c = 0; c < NUM; c++) wd_a[c] = $urandom;
        #1;
        chk("s_pull", s_pull, m_pull ? oh(g) : '0);
        chk("m_wdata", m_wdata, wd_a[g]);
        chk("m_wvalid", m_wvalid, s_wvalid[g]);
        chk("busy_data", busy, 1);
        if (i > 0) chk("s_resp_width", s_resp, 0);
        @(negedge clk);
      end
      m_pull = 1'b0;
      chk("m_len_hold", m_len, el);
      chk("m_addr_hold", m_addr, ea);
      m_done = 1'b1;
      s_wvalid = '1;
      @(negedge clk);
      m_done = 1'b0;
      chk("s_done", s_done, oh(g));
      chk("busy_done", busy, 0);
      chk("m_wvalid_idle", m_wvalid, 0);
      chk("m_wdata_idle", m_wdata, 0);
    end
    if (rearm) s_req[g] = 1'b1;
  endtask

  initial begin
    int g;
    int seq[4];
    rst = 1'b1;
    s_req = '0; s_wvalid = '1; m_resp = 0; m_done = 0; m_pull = 1;
    for (int c = 0; c < NUM; c++) begin
      len_a[c] = LSIZE'($urandom);
      addr_a[c] = ASIZE'($urandom);
      wd_a[c] = $urandom;
    end
    #1;
    chk("rst_m_req", m_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s_pull", s_pull, 0);
    chk("rst_m_wvalid", m_wvalid, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_m_len", m_len, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_resp_done", {s_resp, s_done}, 0);
    m_pull = 0;
    @(negedge clk); rst = 1'b0;

    // responses while idle are ignored
    m_resp = 1; m_done = 1;
    @(negedge clk); m_resp = 0; m_done = 0;
    @(negedge clk);
    chk("idle_ign_resp", s_resp, 0);
    chk("idle_ign_done", s_done, 0);
    chk("idle_ign_busy", busy, 0);

    // single channel, 16 pulls
    len_a[0] = 9'd16; addr_a[0] = 29'h1000; s_req = 4'b0001;
    burst(0, 16, 0, g);
    chk("single_ch", g, 0);

    // m_resp with m_done in the same cycle
    s_req = 4'b0010;
    burst(1, 1, 0, g);
    chk("same_cyc_ch", g, 1);

    // reset in the middle of a data phase
    s_req = 4'b0100;
    last_m = model_pick(s_req);
    g = 0;
    do begin @(negedge clk); g++; end while (!m_req && g < 10);
    m_resp = 1;
    @(negedge clk); m_resp = 0; s_req = '0;
    m_pull = 1; s_wvalid = '1;
    #1 chk("pre_rst_pull", s_pull, 4'b0100);
    #2 rst = 1'b1;
    #1;
    chk("arst_m_req", m_req, 0);
    chk("arst_busy", busy, 0);
    chk("arst_s_pull", s_pull, 0);
    chk("arst_m_wvalid", m_wvalid, 0);
    chk("arst_m_addr", m_addr, 0);
    m_done = 1;
    @(negedge clk);
    m_done = 0; m_pull = 0;
    chk("arst_no_done", s_done, 0);
    rst = 1'b0;
    last_m = NUM - 1;

    // two requesters from reset alternate 0,1,0,1
    s_req = 4'b0011;
    seq = '{0, 1, 0, 1};
    for (int i = 0; i < 4; i++) begin
      burst(i[0], 2, 1, g);
      chk("rr01_order", g, seq[i]);
    end

    // only ch2/ch3 requesting alternate 2,3,2,3
    s_req = 4'b1100;
    seq = '{2, 3, 2, 3};
    for (int i = 0; i < 4; i++) begin
      burst(0, 2, 1, g);
      chk("rr23_order", g, seq[i]);
    end

    // random request mixes
    s_req = '0;
    for (int i = 0; i < 40; i++) begin
      s_req = s_req | NUM'($urandom_range(0, 15));
      if (s_req == '0) s_req[$urandom_range(0, NUM - 1)] = 1'b1;
      burst($urandom_range(0, 3) == 0, $urandom_range(1, 4), 0, g);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_wr_burst_arb.md
# axi_wr_burst_arb

Round-robin arbiter that shares one AXI write engine (`axi_inf_write_state_core`) between NUM independent stream-to-memory channels. Each channel's FIFO-status controller and frame-address generator present burst requests here. The arbiter grants one channel at a time, forwards its length/address to the write engine, and routes the engine's data pull and the AXI W data/valid back to and from the granted channel. It holds the grant until the burst completes, which keeps bursts atomic and W data in AW order.

## Interface
Parameters:
- NUM, 2, number of requesting channels (2..8)
- ASIZE, 29, address width
- LSIZE, 9, burst length field width
- AXI_DSIZE, 256, AXI write data width
- IDW, $clog2(NUM) (min 1), grant index width

Ports:
- axi_aclk  in  1  single clock for all logic
- axi_rst  in  1  asynchronous, active-high reset
- s_req  in  NUM  per-channel burst request (burst_req|tail_req), held until s_resp
- s_len  in  NUM*LSIZE  per-channel burst length, channel i at [i*LSIZE +: LSIZE]
- s_addr  in  NUM*ASIZE  per-channel start address
- s_wdata  in  NUM*AXI_DSIZE  per-channel FIFO dout
- s_wvalid  in  NUM  per-channel !fifo_empty
- s_resp  out  NUM  one-cycle accept pulse to granted channel
- s_done  out  NUM  one-cycle burst-complete pulse to granted channel
- s_pull  out  NUM  FIFO read enable, granted channel only
- m_req  out  1  write_req to engine
- m_len  out  LSIZE  latched length of granted burst
- m_addr  out  ASIZE  latched address of granted burst
- m_resp  in  1  engine req_resp
- m_done  in  1  engine req_done
- m_pull  in  1  engine pull_data_en
- m_wdata  out  AXI_DSIZE  muxed to axi_wdata
- m_wvalid  out  1  muxed to axi_wvalid
- grant_id  out  IDW  current/last granted channel
- busy  out  1  high in REQ or DATA

## Operation
- FSM states:
  - IDLE: if any s_req, pick a winner, latch its s_len/s_addr into m_len/m_addr, set grant_id, go REQ.
  - REQ: m_req=1. On m_resp: pulse s_resp[grant_id]. If m_done is also high, pulse s_done and go IDLE; otherwise go DATA.
  - DATA: m_req=0. On m_done: pulse s_done[grant_id], go IDLE.
- Round-robin: search from (last+1) mod NUM upward, first set s_req wins. `last` updates to the winner at grant. It resets to NUM-1, so channel 0 has first priority.
- Routing:
  - s_pull[grant_id] = m_pull while busy; every other s_pull bit is 0.
  - m_wdata/m_wvalid = the granted channel's s_wdata/s_wvalid while busy; 0 in IDLE.
- Latched length/address do not change while busy, even if the granted channel's s_req/s_len/s_addr change.
- If a requester drops s_req after the grant, the burst still completes.
- m_resp or m_done arriving in IDLE is ignored. m_done in REQ without m_resp is ignored.
- No length arithmetic: LSIZE passes through unchanged.

## Timing
- Reset values:
  - state=IDLE, last=NUM-1, grant_id=0.
  - m_req, s_resp, s_done, busy = 0.
  - m_len, m_addr = 0.
  - Combinational outputs s_pull, m_wdata, m_wvalid = 0.
- Grant latency: s_req sampled high in IDLE at edge k gives m_req=1 from edge k+1.
- m_req stays high until the cycle after m_resp is sampled.
- s_resp/s_done are registered: high exactly one cycle, starting the edge after m_resp/m_done.
- Re-arbitration: after m_done the FSM spends one cycle in IDLE. The earliest next m_req is 2 cycles after the m_done cycle.
- Pull/data paths are combinational, zero latency, with no register between engine and FIFO.
- Reset asserted mid-burst: everything returns to reset values immediately. No s_done is issued for the aborted burst.

## Structure
- Package `vdma_arb_pkg`: FSM state enum (IDLE, REQ, DATA) and a `clog2` constant function.
- Sub-module `rr_pick`: combinational, takes NUM-bit req plus the last pointer, outputs a valid flag and a winner index. It is reusable for a future read-side arbiter.
- Top level holds the FSM, the latches and the mux/demux.

## Test plan
- Single channel: NUM=2, s_req[0]=1, len=16, addr=0x1000 → m_req on the next cycle with m_len=16 and m_addr=0x1000. m_resp → s_resp[0] pulse. 16 m_pull cycles → only s_pull[0] toggles. m_done → s_done[0] pulse, busy=0.
- Simultaneous requests: s_req=2'b11 from reset → order of grants is ch0, ch1, ch0, ch1 across four bursts.
- NUM=4 with only ch2 and ch3 requesting → grants alternate 2,3,2,3 and ch0/ch1 are never granted.
- m_resp and m_done in the same cycle → s_resp and s_done pulse together and the FSM returns to IDLE with no DATA cycle.
- s_addr changed and s_req dropped mid-burst → m_addr is unchanged and the burst completes with s_done.
- axi_rst pulsed during DATA → m_req, s_pull, m_wvalid and busy go to 0 asynchronously. After release, the first grant goes to ch0.
